uart_frame_parser: RTL and testbench



---
 rtl/uart_frame_parser_if.sv | 29 ++
 rtl/uart_frame_parser.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_parser_if.sv
// Byte-stream bundle around uart_frame_parser: the UART-side input stream
// (s_axis_*) and the delimited payload output stream (m_axis_*).
//
// Handshake: a byte moves on a stream in a cycle where tvalid and tready are
// both high at the rising clock edge. A source holding tvalid high keeps
// tdata/tlast/tuser stable and keeps tvalid high until that transfer happens.
// A sink may change tready freely. tuser is meaningful only together with tlast.
interface uart_frame_parser_if;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;
  logic       m_axis_tuser;

  // Parser side
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );

  // Environment side: drives the UART bytes, consumes the payload
  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );
endinterface

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: hunts for SOF, reads LEN, LEN payload bytes and a
// checksum byte, and re-emits the payload as a packet with tlast on the final
// byte and tuser = bad frame. The last payload byte is held in a pending
// register until the following byte arrives, so its tlast/tuser are known
// before it is presented downstream.
// Optional feature macro: UART_FRAME_TIMEOUT_EN enables the inter-byte
// timeout (idle counter, timeout_error pulse, FLUSH state).
module uart_frame_parser #(
  parameter logic [7:0] SOF_BYTE = 8'hA5,
  parameter int         MAX_LEN  = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  uart_frame_parser_if.slave         bus,
  input  logic [15:0]                timeout,
  output logic                       busy,
  output logic                       frame_ok,
  output logic                       csum_error,
  output logic                       len_error,
  output logic                       timeout_error,
  output logic [2:0]                 dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CSUM    = 3'd3,
    S_FLUSH   = 3'd4
  } state_t;

  localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

  state_t     state_q, state_d;
  logic [7:0] pend_q, pend_d;
  logic       pend_vld_q, pend_vld_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_vld_q, out_vld_d;
  logic       out_last_q, out_last_d;
  logic       out_user_q, out_user_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] acc_q, acc_d;
  logic       frame_ok_q, frame_ok_d;
  logic       csum_err_q, csum_err_d;
  logic       len_err_q, len_err_d;
  logic       to_err_q, to_err_d;

  logic       s_ready;
  logic       accept;
  logic       out_free;
  logic [7:0] frame_sum;
  logic       to_fire;

  assign out_free  = !out_vld_q || bus.m_axis_tready;
  assign accept    = bus.s_axis_tvalid && s_ready;
  assign frame_sum = acc_q + bus.s_axis_tdata;

  // Input ready: a payload/checksum byte is taken only if pending can drain
  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      S_IDLE, S_LEN:      s_ready = 1'b1;
      S_PAYLOAD, S_CSUM:  s_ready = !pend_vld_q || out_free;
      default:            s_ready = 1'b0;
    endcase
  end

`ifdef UART_FRAME_TIMEOUT_EN
  logic [15:0] idle_q, idle_d;

  // Idle counter: cleared by any accepted byte, frozen while we stall the UART
  always_comb begin
    idle_d  = idle_q;
    to_fire = 1'b0;
    if (state_q == S_IDLE || state_q == S_FLUSH || accept) begin
      idle_d = 16'd0;
    end else if (!(bus.s_axis_tvalid && !s_ready)) begin
      idle_d = idle_q + 16'd1;
    end
    if (timeout != 16'd0 && state_q != S_IDLE && state_q != S_FLUSH &&
        !accept && idle_q == timeout) begin
      to_fire = 1'b1;
      idle_d  = 16'd0;
    end
  end

  // Idle counter register
  always_ff @(posedge clk) begin
    if (rst) idle_q <= 16'd0;
    else     idle_q <= idle_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout;
  assign to_fire        = 1'b0;
`endif

  // Frame FSM next state, pending/output register moves and status pulses
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    out_data_d = out_data_q;
    out_vld_d  = out_vld_q;
    out_last_d = out_last_q;
    out_user_d = out_user_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    frame_ok_d = 1'b0;
    csum_err_d = 1'b0;
    len_err_d  = 1'b0;
    to_err_d   = 1'b0;

    if (out_vld_q && bus.m_axis_tready) out_vld_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept && bus.s_axis_tdata == SOF_BYTE) begin
          acc_d   = 8'd0;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (accept) begin
          if (bus.s_axis_tdata == 8'd0 || {1'b0, bus.s_axis_tdata} > MAX_LEN_W) begin
            len_err_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            cnt_d   = bus.s_axis_tdata;
            acc_d   = bus.s_axis_tdata;
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (accept) begin
          acc_d = frame_sum;
          if (pend_vld_q) begin
            out_data_d = pend_q;
            out_vld_d  = 1'b1;
            out_last_d = 1'b0;
            out_user_d = 1'b0;
          end
          pend_d     = bus.s_axis_tdata;
          pend_vld_d = 1'b1;
          cnt_d      = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (accept) begin
          out_data_d = pend_q;
          out_vld_d  = 1'b1;
          out_last_d = 1'b1;
          out_user_d = (frame_sum != 8'd0);
          pend_vld_d = 1'b0;
          frame_ok_d = (frame_sum == 8'd0);
          csum_err_d = (frame_sum != 8'd0);
          state_d    = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (out_free) begin
          out_data_d = pend_q;
          out_vld_d  = 1'b1;
          out_last_d = 1'b1;
          out_user_d = 1'b1;
          pend_vld_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A timeout never coincides with an accepted byte, so it simply overrides
    if (to_fire) begin
      to_err_d = 1'b1;
      state_d  = pend_vld_q ? S_FLUSH : S_IDLE;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pend_q     <= 8'd0;
      pend_vld_q <= 1'b0;
      out_data_q <= 8'd0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_user_q <= 1'b0;
      cnt_q      <= 8'd0;
      acc_q      <= 8'd0;
      frame_ok_q <= 1'b0;
      csum_err_q <= 1'b0;
      len_err_q  <= 1'b0;
      to_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      out_data_q <= out_data_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
      out_user_q <= out_user_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      frame_ok_q <= frame_ok_d;
      csum_err_q <= csum_err_d;
      len_err_q  <= len_err_d;
      to_err_q   <= to_err_d;
    end
  end

  assign bus.s_axis_tready = s_ready;
  assign bus.m_axis_tdata  = out_data_q;
  assign bus.m_axis_tvalid = out_vld_q;
  assign bus.m_axis_tlast  = out_last_q;
  assign bus.m_axis_tuser  = out_user_q;
  assign busy              = (state_q != S_IDLE);
  assign frame_ok          = frame_ok_q;
  assign csum_error        = csum_err_q;
  assign len_error         = len_err_q;
  assign timeout_error     = to_err_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: directed frames from the test plan plus
// randomized frame streams, with a reference parse of each byte stream
// producing the expected payload packets and status-pulse counts.
module tb_uart_frame_parser;

  localparam int MAX_MAIN = 255;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] timeout = 16'd0;
  logic busy, frame_ok, csum_error, len_error, timeout_error;
  logic [2:0] dbg_state;
  logic busy4, ok4, cs4, le4, te4;
  logic [2:0] dbg4;

  uart_frame_parser_if bus ();
  uart_frame_parser_if bus4 ();

  uart_frame_parser dut (
    .clk(clk), .rst(rst), .bus(bus), .timeout(timeout),
    .busy(busy), .frame_ok(frame_ok), .csum_error(csum_error),
    .len_error(len_error), .timeout_error(timeout_error), .dbg_state(dbg_state)
  );

  uart_frame_parser #(.MAX_LEN(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .timeout(16'd0),
    .busy(busy4), .frame_ok(ok4), .csum_error(cs4),
    .len_error(le4), .timeout_error(te4), .dbg_state(dbg4)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [9:0] exp_q[$];           // {tuser, tlast, tdata}
  logic [7:0] stim_q[$];
  int exp_ok = 0, exp_cs = 0, exp_le = 0, exp_te = 0;
  int got_ok = 0, got_cs = 0, got_le = 0, got_te = 0;
  int got_ok4 = 0, got_le4 = 0, got_n4 = 0;
  logic       stall_prev = 1'b0;
  logic [9:0] held = '0;
  bit         saw_sstall = 0;

  // Reference parse: walk the byte list frame by frame using the framing rules
  task automatic model();
    int i;
    int len;
    logic [7:0] sum;
    i = 0;
    while (i < stim_q.size()) begin
      if (stim_q[i] != 8'hA5) begin
        i++;
        continue;
      end
      len = int'(stim_q[i+1]);
      i += 2;
      if (len == 0 || len > MAX_MAIN) begin
        exp_le++;
        continue;
      end
      sum = 8'(len);
      for (int k = 0; k <= len; k++) sum = sum + stim_q[i+k];
      for (int k = 0; k < len; k++)
        exp_q.push_back({(k == len-1) && (sum != 8'd0), k == len-1, stim_q[i+k]});
      if (sum == 8'd0) exp_ok++;
      else exp_cs++;
      i += len + 1;
    end
  endtask

  // Output monitor, sampled mid-cycle: each sample describes the next edge
  always @(negedge clk) begin
    logic [9:0] cur;
    #2;
    if (!rst) begin
      got_ok  += int'(frame_ok);
      got_cs  += int'(csum_error);
      got_le  += int'(len_error);
      got_te  += int'(timeout_error);
      got_ok4 += int'(ok4);
      got_le4 += int'(le4);
      got_n4  += int'(bus4.m_axis_tvalid && bus4.m_axis_tready);
      cur = {bus.m_axis_tuser, bus.m_axis_tlast, bus.m_axis_tdata};
      if (stall_prev) chk("hold_stable", {21'd0, bus.m_axis_tvalid, cur}, {21'd0, 1'b1, held});
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (exp_q.size() == 0) chk("extra_out", 32'(exp_q.size()), 32'd1);
        else chk("out_byte", 32'(cur), 32'(exp_q.pop_front()));
      end
      stall_prev = bus.m_axis_tvalid && !bus.m_axis_tready;
      held = cur;
      if (bus.s_axis_tvalid && !bus.s_axis_tready) saw_sstall = 1;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // ---------------- downstream ready driver ----------------
  int ready_mode = 0;   // 0 always, 1 random, 2 one 20-cycle stall, 3 never
  int bp_cnt = 0;
  bit bp_used = 0;
  always @(negedge clk) begin
    case (ready_mode)
      0: bus.m_axis_tready = 1'b1;
      1: bus.m_axis_tready = ($urandom_range(0, 3) != 0);
      2: begin
        if (bp_cnt > 0) begin
          bus.m_axis_tready = 1'b0;
          bp_cnt--;
        end else if (!bp_used && bus.m_axis_tvalid) begin
          bp_used = 1;
          bp_cnt = 19;
          bus.m_axis_tready = 1'b0;
        end else begin
          bus.m_axis_tready = 1'b1;
        end
      end
      default: bus.m_axis_tready = 1'b0;
    endcase
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int n;
    bit rdy;
    n = 0;
    @(negedge clk);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = b;
    forever begin
      #1 rdy = bus.s_axis_tready;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 2000) begin
        chk("send_stuck", 32'(n), 32'd0);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle_cycles(input int k);
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
    repeat (k - 1) @(negedge clk);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
    #3;
    while ((exp_q.size() != 0 || busy) && n < 5000) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("drain_in_time", 32'(n < 5000), 32'd1);
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_frame_ok"}, 32'(got_ok), 32'(exp_ok));
    chk({tag, "_csum_err"}, 32'(got_cs), 32'(exp_cs));
    chk({tag, "_len_err"},  32'(got_le), 32'(exp_le));
    chk({tag, "_to_err"},   32'(got_te), 32'(exp_te));
    chk({tag, "_busy"},     32'(busy), 32'd0);
  endtask

  // Model the queued bytes, send them (random gaps up to gap_max), check
  task automatic run_stream(input string tag, input int gap_max);
    model();
    foreach (stim_q[i]) begin
      send_byte(stim_q[i]);
      if (gap_max > 0 && $urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, gap_max));
    end
    stim_q.delete();
    wait_drain();
    check_counts(tag);
  endtask

  task automatic push_bytes(input logic [7:0] b0, input int n, input logic [63:0] rest);
    stim_q.push_back(b0);
    for (int i = n - 1; i >= 0; i--) stim_q.push_back(rest[i*8 +: 8]);
  endtask

  task automatic add_frame(input int len, input bit bad_cs);
    logic [7:0] s;
    logic [7:0] b;
    s = 8'(len);
    stim_q.push_back(8'hA5);
    stim_q.push_back(8'(len));
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom_range(0, 255));
      s = s + b;
      stim_q.push_back(b);
    end
    s = 8'd0 - s;
    if (bad_cs) s = s + 8'($urandom_range(1, 255));
    stim_q.push_back(s);
  endtask

  task automatic add_garbage(input int n);
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h00;
      stim_q.push_back(b);
    end
  endtask

  // ---------------- main sequence ----------------
  logic [7:0] seq4 [0:8] = '{8'hA5, 8'h05, 8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF2};

  initial begin
    bus.s_axis_tvalid  = 1'b0;
    bus.s_axis_tdata   = 8'h00;
    bus4.s_axis_tvalid = 1'b0;
    bus4.s_axis_tdata  = 8'h00;
    bus4.m_axis_tready = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    #3;
    chk("rst_outputs", {26'd0, bus.m_axis_tvalid, busy, frame_ok, csum_error, len_error, timeout_error},
        32'd0);
    chk("rst_s_ready", 32'(bus.s_axis_tready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #3;
    chk("post_rst_idle", {29'd0, bus.m_axis_tvalid, busy, bus.s_axis_tready}, 32'd1);

    // good frame
    push_bytes(8'hA5, 5, 64'h03_11_22_33_97);
    run_stream("good", 0);

    // bad checksum
    push_bytes(8'hA5, 5, 64'h03_11_22_33_00);
    run_stream("badcs", 0);

    // hunt through garbage
    push_bytes(8'h00, 6, 64'hFF_3C_A5_01_7E_81);
    run_stream("hunt", 0);

    // zero length, then a clean frame
    push_bytes(8'hA5, 5, 64'h00_A5_01_7E_81);
    run_stream("len0", 0);

    // downstream stall of 20 cycles after first output
    saw_sstall = 0;
    bp_used = 0;
    ready_mode = 2;
    add_frame(6, 0);
    run_stream("bp", 0);
    chk("bp_s_ready_dropped", 32'(saw_sstall), 32'd1);

    // randomized streams
    ready_mode = 1;
    for (int f = 0; f < 40; f++) begin
      add_garbage($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        stim_q.push_back(8'hA5);
        stim_q.push_back(8'h00);
      end else begin
        add_frame($urandom_range(1, 8), $urandom_range(0, 3) == 0);
      end
    end
    run_stream("rand", 2);

    // longest legal frame, back-to-back
    ready_mode = 0;
    add_frame(255, 0);
    run_stream("len255", 0);

    // MAX_LEN = 4 instance: LEN 5 rejected, LEN 4 accepted
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus4.s_axis_tdata  = seq4[i];
      bus4.s_axis_tvalid = 1'b1;
    end
    @(negedge clk);
    bus4.s_axis_tvalid = 1'b0;
    repeat (6) @(negedge clk);
    #3;
    chk("max4_len_err", 32'(got_le4), 32'd1);
    chk("max4_frame_ok", 32'(got_ok4), 32'd1);
    chk("max4_out_bytes", 32'(got_n4), 32'd4);

`ifdef UART_FRAME_TIMEOUT_EN
    // inter-byte timeout with one pending byte
    timeout = 16'd100;
    exp_q.push_back({1'b1, 1'b1, 8'h11});
    exp_te++;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    wait_drain();
    check_counts("timeout");
    push_bytes(8'hA5, 5, 64'h03_11_22_33_97);
    run_stream("after_to", 0);
    timeout = 16'd0;
`endif

    // reset in mid-frame with output blocked: nothing may leak afterwards
    ready_mode = 3;
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #3;
    chk("midrst_clear", {30'd0, bus.m_axis_tvalid, busy}, 32'd0);
    rst = 1'b0;
    ready_mode = 0;
    push_bytes(8'hA5, 3, 64'h01_7E_81);
    run_stream("midrst", 0);
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
